// File: rtl/fetch_queue_if.sv
// Fetch-to-decode queue bus: push side from fetch, pop side to decode.
// master drives requests into the queue; slave is the queue itself.
interface fetch_queue_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            flush;
    logic            push_valid;
    logic [XLEN-1:0] push_pc;
    logic [XLEN-1:0] push_instr;
    logic            push_ready;
    logic            fetch_stall;
    logic            pop_valid;
    logic [XLEN-1:0] pop_pc;
    logic [XLEN-1:0] pop_instr;
    logic            pop_ready;
    logic [CW-1:0]   count;

    modport master (
        output flush, push_valid, push_pc, push_instr, pop_ready,
        input  push_ready, fetch_stall, pop_valid, pop_pc, pop_instr, count
    );

    modport slave (
        input  flush, push_valid, push_pc, push_instr, pop_ready,
        output push_ready, fetch_stall, pop_valid, pop_pc, pop_instr, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Elastic {pc, instr} FIFO between fetch and decode with flush.
// Outputs depend only on registered state; no push-to-pop bypass.
module fetch_queue #(
    parameter int              DEPTH = 4,
    parameter int              XLEN  = 32,
    parameter logic [XLEN-1:0] NOP   = 32'h00000013
) (
    input logic         clock,
    input logic         reset,
    fetch_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] mem_pc    [DEPTH];
    logic [XLEN-1:0] mem_instr [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic empty;
    logic full;
    logic push_fire;
    logic pop_fire;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    assign push_fire = bus.push_valid & ~full & ~bus.flush;
    assign pop_fire  = bus.pop_ready & ~empty & ~bus.flush;

    assign bus.push_ready  = ~full;
    assign bus.fetch_stall = full;
    assign bus.pop_valid   = ~empty;
    assign bus.pop_pc      = empty ? '0 : mem_pc[rd_ptr];
    assign bus.pop_instr   = empty ? NOP : mem_instr[rd_ptr];
    assign bus.count       = count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc[i]    <= '0;
                mem_instr[i] <= '0;
            end
        end else if (bus.flush) begin
            // storage is left stale; pointers alone define validity
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) begin
                mem_pc[wr_ptr]    <= bus.push_pc;
                mem_instr[wr_ptr] <= bus.push_instr;
                wr_ptr            <= wr_ptr + AW'(1);
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push_fire, pop_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: queue-based model checked every
// cycle, plus literal expectations taken from hand-worked scenarios.
module tb_fetch_queue;
    localparam int          DEPTH = 4;
    localparam int          XLEN  = 32;
    localparam logic [31:0] NOP   = 32'h00000013;
    localparam logic [31:0] IBASE = 32'hC0DE0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;
    ent_t model[$];

    fetch_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .NOP(NOP)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endfunction

    // Reference behaviour: a bounded queue with flush
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            model.delete();
        end else if (bus.flush) begin
            model.delete();
        end else begin
            bit can_push;
            bit can_pop;
            ent_t e;
            can_push = bus.push_valid && (model.size() < DEPTH);
            can_pop  = bus.pop_ready && (model.size() > 0);
            if (can_pop) void'(model.pop_front());
            if (can_push) begin
                e.pc    = bus.push_pc;
                e.instr = bus.push_instr;
                model.push_back(e);
            end
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            int n;
            n = model.size();
            chk("cyc_count", 32'(bus.count), 32'(n));
            chk("cyc_pop_valid", 32'(bus.pop_valid), 32'(n != 0));
            chk("cyc_push_ready", 32'(bus.push_ready), 32'(n != DEPTH));
            chk("cyc_fetch_stall", 32'(bus.fetch_stall), 32'(n == DEPTH));
            chk("cyc_pop_pc", bus.pop_pc, (n != 0) ? model[0].pc : 32'h0);
            chk("cyc_pop_instr", bus.pop_instr, (n != 0) ? model[0].instr : NOP);
        end
    end

    task automatic drive(input bit pv, input logic [31:0] pc,
                         input bit pr, input bit fl);
        bus.push_valid = pv;
        bus.push_pc    = pc;
        bus.push_instr = IBASE + pc;
        bus.pop_ready  = pr;
        bus.flush      = fl;
        @(posedge clock);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset          = 1'b1;
        bus.flush      = 1'b0;
        bus.push_valid = 1'b0;
        bus.push_pc    = '0;
        bus.push_instr = '0;
        bus.pop_ready  = 1'b0;
        #12;
        reset = 1'b0;
        chk("rst_push_ready", 32'(bus.push_ready), 32'd1);
        chk("rst_fetch_stall", 32'(bus.fetch_stall), 32'd0);
        chk("rst_pop_valid", 32'(bus.pop_valid), 32'd0);
        chk("rst_pop_pc", bus.pop_pc, 32'h0);
        chk("rst_pop_instr", bus.pop_instr, NOP);
        chk("rst_count", 32'(bus.count), 32'd0);
        @(posedge clock);
        #1;

        for (int i = 0; i < 4; i++) drive(1'b1, 32'(4 * i), 1'b0, 1'b0);
        chk("full_count", 32'(bus.count), 32'd4);
        chk("full_push_ready", 32'(bus.push_ready), 32'd0);
        chk("full_fetch_stall", 32'(bus.fetch_stall), 32'd1);
        chk("full_pop_pc", bus.pop_pc, 32'h0);
        chk("full_pop_instr", bus.pop_instr, 32'hC0DE0000);

        drive(1'b1, 32'h10, 1'b1, 1'b0);
        chk("fullpop_count", 32'(bus.count), 32'd3);
        chk("fullpop_push_ready", 32'(bus.push_ready), 32'd1);
        chk("fullpop_pop_pc", bus.pop_pc, 32'h4);
        chk("fullpop_pop_instr", bus.pop_instr, 32'hC0DE0004);

        for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("drain_count", 32'(bus.count), 32'd0);

        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'(4 * i), 1'b1, 1'b0);
            chk("stream_count", 32'(bus.count), 32'd1);
            chk("stream_pop_pc", bus.pop_pc, 32'(4 * i));
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("stream_end_count", 32'(bus.count), 32'd0);

        drive(1'b1, 32'h100, 1'b0, 1'b0);
        drive(1'b1, 32'h104, 1'b0, 1'b0);
        chk("preflush_count", 32'(bus.count), 32'd2);
        drive(1'b1, 32'h108, 1'b1, 1'b1);
        chk("flush_count", 32'(bus.count), 32'd0);
        chk("flush_pop_valid", 32'(bus.pop_valid), 32'd0);
        chk("flush_pop_instr", bus.pop_instr, 32'h00000013);
        chk("flush_push_ready", 32'(bus.push_ready), 32'd1);
        drive(1'b1, 32'h40, 1'b0, 1'b0);
        chk("postflush_pop_pc", bus.pop_pc, 32'h40);
        chk("postflush_count", 32'(bus.count), 32'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            chk("empty_count", 32'(bus.count), 32'd0);
            chk("empty_pop_pc", bus.pop_pc, 32'h0);
        end
        bus.push_valid = 1'b1;
        bus.push_pc    = 32'h80;
        bus.push_instr = IBASE + 32'h80;
        bus.pop_ready  = 1'b0;
        #1;
        chk("nobypass_pop_valid", 32'(bus.pop_valid), 32'd0);
        @(posedge clock);
        #1;
        chk("late_pop_valid", 32'(bus.pop_valid), 32'd1);
        chk("late_pop_pc", bus.pop_pc, 32'h80);

        drive(1'b1, 32'h84, 1'b0, 1'b0);
        drive(1'b1, 32'h88, 1'b0, 1'b0);
        chk("prerst_count", 32'(bus.count), 32'd3);
        bus.push_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_count", 32'(bus.count), 32'd0);
        chk("async_rst_pop_valid", 32'(bus.pop_valid), 32'd0);
        chk("async_rst_pop_instr", bus.pop_instr, NOP);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
